scurve_scan_ctrl: RTL and testbench



---
 rtl/scurve_pkg.sv | 20 ++
 rtl/scurve_scan_ctrl_if.sv | 11 +
 rtl/scurve_settle_timer.sv | 36 +++
 rtl/scurve_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_scurve_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scurve_pkg.sv
// Shared types and constants for the S-curve scan controller slice.
package scurve_pkg;

  localparam int DAC_WIDTH_DEF  = 10;
  localparam int WORDS_PER_STEP = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLEAR  = 4'd1,
    ST_LOAD   = 4'd2,
    ST_SETTLE = 4'd3,
    ST_RUN    = 4'd4,
    ST_WR0    = 4'd5,
    ST_WR1    = 4'd6,
    ST_WR2    = 4'd7,
    ST_NEXT   = 4'd8,
    ST_DONE   = 4'd9
  } scan_state_e;

endpackage

// File: rtl/scurve_scan_ctrl_if.sv
// Readout stream towards the FIFO: 16-bit words with a valid/ready handshake.
interface scurve_scan_ctrl_if;

  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/scurve_settle_timer.sv
// 16-bit load/countdown timer; done_o is high while the count sits at zero.
module scurve_settle_timer (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        done_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 16'd0) begin
      count_d = count_q - 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 16'd0);

endmodule

// File: rtl/scurve_scan_ctrl.sv
// Sweeps the threshold DAC code and streams one (code, pulse, trigger)
// word triple per step to the readout FIFO.
module scurve_scan_ctrl
  import scurve_pkg::*;
#(
  parameter int DAC_WIDTH     = DAC_WIDTH_DEF,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CLR_CYCLES    = 2
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 scan_start_i,
  input  logic                 scan_abort_i,
  input  logic [DAC_WIDTH-1:0] dac_start_i,
  input  logic [DAC_WIDTH-1:0] dac_end_i,
  input  logic [DAC_WIDTH-1:0] dac_step_i,
  input  logic [15:0]          cpt_pulse_i,
  input  logic [15:0]          cpt_trigger_i,
  input  logic                 cpt_done_i,
  output logic                 count_rst_n_o,
  output logic                 test_start_o,
  output logic [DAC_WIDTH-1:0] dac_code_o,
  output logic                 dac_load_o,
  output logic                 scan_busy_o,
  output logic                 scan_done_o,
  scurve_scan_ctrl_if.master   out_if
);

  // Timers are loaded with N-1 so that the waiting state lasts exactly N cycles.
  localparam logic [15:0]          CLR_LOAD    = 16'(CLR_CYCLES - 1);
  localparam logic [15:0]          SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [DAC_WIDTH-1:0] CODE_ZERO   = {DAC_WIDTH{1'b0}};
  localparam logic [DAC_WIDTH-1:0] STEP_ONE    = {{(DAC_WIDTH-1){1'b0}}, 1'b1};

  scan_state_e          state_q, state_d;
  logic [DAC_WIDTH-1:0] dac_code_q, dac_code_d;
  logic [DAC_WIDTH-1:0] end_q, end_d;
  logic [DAC_WIDTH-1:0] step_q, step_d;
  logic [15:0]          pulse_q, pulse_d;
  logic [15:0]          trig_q, trig_d;
  logic                 count_rst_n_q, count_rst_n_d;
  logic                 test_start_q, test_start_d;
  logic                 dac_load_q, dac_load_d;
  logic [15:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 scan_busy_q, scan_busy_d;
  logic                 scan_done_q, scan_done_d;

  logic [DAC_WIDTH:0]   nxt_s;
  logic                 xfer_s;
  logic                 timer_load_s;
  logic [15:0]          timer_val_s;
  logic                 timer_done_s;

  scurve_settle_timer u_timer (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .load_i     (timer_load_s),
    .load_val_i (timer_val_s),
    .done_o     (timer_done_s)
  );

  assign xfer_s = out_valid_q & out_if.out_ready;
  assign nxt_s  = {1'b0, dac_code_q} + {1'b0, step_q};

  // Next state, scan latches, timer control and next registered outputs.
  always_comb begin
    state_d      = state_q;
    dac_code_d   = dac_code_q;
    end_d        = end_q;
    step_d       = step_q;
    pulse_d      = pulse_q;
    trig_d       = trig_q;
    out_data_d   = out_data_q;
    timer_load_s = 1'b0;
    timer_val_s  = CLR_LOAD;

    if (scan_abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_start_i && !scan_abort_i) begin
            state_d    = ST_CLEAR;
            dac_code_d = dac_start_i;
            end_d      = dac_end_i;
            step_d     = (dac_step_i == CODE_ZERO) ? STEP_ONE : dac_step_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR:  state_d = timer_done_s ? ST_LOAD : ST_CLEAR;
        ST_LOAD:   state_d = ST_SETTLE;
        ST_SETTLE: state_d = timer_done_s ? ST_RUN : ST_SETTLE;
        ST_RUN: begin
          if (cpt_done_i) begin
            state_d = ST_WR0;
            pulse_d = cpt_pulse_i;
            trig_d  = cpt_trigger_i;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WR0: state_d = xfer_s ? ST_WR1 : ST_WR0;
        ST_WR1: state_d = xfer_s ? ST_WR2 : ST_WR1;
        ST_WR2: state_d = xfer_s ? ST_NEXT : ST_WR2;
        ST_NEXT: begin
          // nxt_s carries one extra bit so a wrap past the top code ends the sweep.
          if ((dac_code_q >= end_q) || (nxt_s > {1'b0, end_q}) || nxt_s[DAC_WIDTH]) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_CLEAR;
            dac_code_d = nxt_s[DAC_WIDTH-1:0];
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
      timer_load_s = 1'b1;
      timer_val_s  = CLR_LOAD;
    end else if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
      timer_load_s = 1'b1;
      timer_val_s  = SETTLE_LOAD;
    end else begin
      timer_load_s = 1'b0;
      timer_val_s  = CLR_LOAD;
    end

    count_rst_n_d = (state_d != ST_CLEAR);
    test_start_d  = (state_d == ST_RUN);
    dac_load_d    = (state_d == ST_LOAD);
    out_valid_d   = (state_d == ST_WR0) || (state_d == ST_WR1) || (state_d == ST_WR2);
    scan_busy_d   = (state_d != ST_IDLE);
    scan_done_d   = (state_d == ST_DONE);

    case (state_d)
      ST_WR0:  out_data_d = 16'(dac_code_d);
      ST_WR1:  out_data_d = pulse_d;
      ST_WR2:  out_data_d = trig_d;
      default: out_data_d = out_data_q;
    endcase
  end

  // State, scan latches and all output registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      dac_code_q    <= CODE_ZERO;
      end_q         <= CODE_ZERO;
      step_q        <= CODE_ZERO;
      pulse_q       <= 16'd0;
      trig_q        <= 16'd0;
      count_rst_n_q <= 1'b1;
      test_start_q  <= 1'b0;
      dac_load_q    <= 1'b0;
      out_data_q    <= 16'd0;
      out_valid_q   <= 1'b0;
      scan_busy_q   <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dac_code_q    <= dac_code_d;
      end_q         <= end_d;
      step_q        <= step_d;
      pulse_q       <= pulse_d;
      trig_q        <= trig_d;
      count_rst_n_q <= count_rst_n_d;
      test_start_q  <= test_start_d;
      dac_load_q    <= dac_load_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      scan_busy_q   <= scan_busy_d;
      scan_done_q   <= scan_done_d;
    end
  end

  assign count_rst_n_o    = count_rst_n_q;
  assign test_start_o     = test_start_q;
  assign dac_code_o       = dac_code_q;
  assign dac_load_o       = dac_load_q;
  assign scan_busy_o      = scan_busy_q;
  assign scan_done_o      = scan_done_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_scurve_scan_ctrl.sv
// Directed bench for scurve_scan_ctrl: table of sweeps plus hand-written
// timing, abort and reset sequences.
module tb_scurve_scan_ctrl;
  import scurve_pkg::*;

  localparam int DW     = 10;
  localparam int SETTLE = 8;
  localparam int CLR    = 2;
  localparam int DLY    = 50;

  typedef struct {
    logic [DW-1:0] st;
    logic [DW-1:0] en;
    logic [DW-1:0] sp;
    logic [15:0]   p;
    logic [15:0]   t;
    int            rm;
    int            n;
    int            c0;
    int            inc;
  } vec_t;

  logic          Clk;
  logic          reset_n;
  logic          scan_start, scan_abort;
  logic [DW-1:0] dac_start, dac_end, dac_step;
  logic [15:0]   cpt_pulse, cpt_trigger;
  logic          mdl_done, man_done, cpt_done;
  logic          count_rst_n, test_start, dac_load, scan_busy, scan_done;
  logic [DW-1:0] dac_code;

  scurve_scan_ctrl_if bus ();

  assign cpt_done = mdl_done | man_done;

  scurve_scan_ctrl #(.DAC_WIDTH(DW), .SETTLE_CYCLES(SETTLE), .CLR_CYCLES(CLR)) dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .scan_start_i  (scan_start),
    .scan_abort_i  (scan_abort),
    .dac_start_i   (dac_start),
    .dac_end_i     (dac_end),
    .dac_step_i    (dac_step),
    .cpt_pulse_i   (cpt_pulse),
    .cpt_trigger_i (cpt_trigger),
    .cpt_done_i    (cpt_done),
    .count_rst_n_o (count_rst_n),
    .test_start_o  (test_start),
    .dac_code_o    (dac_code),
    .dac_load_o    (dac_load),
    .scan_busy_o   (scan_busy),
    .scan_done_o   (scan_done),
    .out_if        (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ts_cnt = 0;
  int n_load = 0;
  int n_done = 0;
  int rdy_mode = 0;
  logic mdl_en = 1'b1;
  logic stab_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic [15:0] words[$];
  vec_t vecs[7];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Environment: counter-block model, FIFO ready pattern, word capture, event counts.
  initial begin
    mdl_done = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge Clk);
      cyc++;
      if (test_start) ts_cnt++;
      else ts_cnt = 0;
      mdl_done = mdl_en && (ts_cnt == DLY);
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (stab_en && prev_stall) begin
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_data_stable", 32'(bus.out_data), 32'(prev_data));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) words.push_back(bus.out_data);
      if (dac_load) n_load++;
      if (scan_done) n_done++;
    end
  end

  task automatic start_scan(input logic [DW-1:0] st, input logic [DW-1:0] en, input logic [DW-1:0] sp);
    @(negedge Clk);
    dac_start = st; dac_end = en; dac_step = sp;
    scan_start = 1'b1;
    @(negedge Clk);
    scan_start = 1'b0;
    // Scrambled parameters must be ignored once the scan is running.
    dac_start = 10'd341; dac_end = 10'd1023; dac_step = 10'd1;
  endtask

  task automatic run_scan(input vec_t v, input int vi);
    int t;
    int k;
    logic [31:0] exp_w;
    words.delete();
    n_load = 0; n_done = 0;
    cpt_pulse = v.p; cpt_trigger = v.t;
    rdy_mode = v.rm; stab_en = 1'b1; mdl_en = 1'b1;
    start_scan(v.st, v.en, v.sp);
    t = 0;
    while (n_done == 0 && t < 4000) begin
      @(negedge Clk);
      t++;
    end
    repeat (3) @(negedge Clk);
    stab_en = 1'b0;
    chk($sformatf("v%0d_scan_done_count", vi), 32'(n_done), 32'd1);
    chk($sformatf("v%0d_busy_after", vi), 32'(scan_busy), 32'd0);
    chk($sformatf("v%0d_dac_load_count", vi), 32'(n_load), 32'(v.n));
    chk($sformatf("v%0d_word_count", vi), 32'(words.size()), 32'(v.n * WORDS_PER_STEP));
    for (int i = 0; i < v.n; i++) begin
      for (int w = 0; w < 3; w++) begin
        k = i * 3 + w;
        exp_w = (w == 0) ? 32'(v.c0 + i * v.inc) : ((w == 1) ? 32'(v.p) : 32'(v.t));
        chk($sformatf("v%0d_word%0d", vi, k), (k < words.size()) ? 32'(words[k]) : 32'hFFFF_FFFF, exp_w);
      end
    end
  endtask

  initial begin
    int n;
    int clr;
    reset_n = 1'b0;
    scan_start = 1'b0; scan_abort = 1'b0;
    dac_start = 10'd0; dac_end = 10'd0; dac_step = 10'd0;
    cpt_pulse = 16'd0; cpt_trigger = 16'd0; man_done = 1'b0;

    //               st        en        sp       pulse     trig     rm  n  c0    inc
    vecs[0] = '{10'd10,   10'd14,   10'd2,   16'd1000, 16'd600, 0, 3, 10,   2};
    vecs[1] = '{10'd10,   10'd14,   10'd2,   16'd1000, 16'd600, 1, 3, 10,   2};
    vecs[2] = '{10'd1020, 10'd1023, 10'd5,   16'd77,   16'd33,  0, 1, 1020, 5};
    vecs[3] = '{10'd1023, 10'd1023, 10'd1,   16'd5,    16'd6,   0, 1, 1023, 1};
    vecs[4] = '{10'd20,   10'd10,   10'd3,   16'd9,    16'd8,   1, 1, 20,   3};
    vecs[5] = '{10'd0,    10'd3,    10'd0,   16'd400,  16'd200, 0, 4, 0,    1};
    vecs[6] = '{10'd0,    10'd1023, 10'd512, 16'd65535,16'd1,   0, 2, 0,    512};

    repeat (3) @(negedge Clk);
    chk("rst_count_rst_n", 32'(count_rst_n), 32'd1);
    chk("rst_test_start", 32'(test_start), 32'd0);
    chk("rst_dac_code", 32'(dac_code), 32'd0);
    chk("rst_dac_load", 32'(dac_load), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_scan_busy", 32'(scan_busy), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 7; i++) run_scan(vecs[i], i);

    // Clear length, settle latency, cpt_done ignored in SETTLE, test_start drop.
    mdl_en = 1'b0; rdy_mode = 0; words.delete(); n_done = 0;
    cpt_pulse = 16'd111; cpt_trigger = 16'd222;
    start_scan(10'd5, 10'd5, 10'd1);
    clr = 0; n = 0;
    while (!dac_load && n < 30) begin
      if (!count_rst_n) clr++;
      @(negedge Clk);
      n++;
    end
    chk("clr_low_cycles", 32'(clr), 32'(CLR));
    chk("load_dac_code", 32'(dac_code), 32'd5);
    n = 0;
    while (!test_start && n < 40) begin
      @(negedge Clk);
      n++;
      if (n == 3) man_done = 1'b1;
      if (n == 4) man_done = 1'b0;
    end
    chk("load_to_test_start", 32'(n), 32'(SETTLE + 1));
    man_done = 1'b1;
    @(negedge Clk);
    man_done = 1'b0;
    chk("test_start_fall", 32'(test_start), 32'd0);
    chk("wr0_valid", 32'(bus.out_valid), 32'd1);
    chk("wr0_code", 32'(bus.out_data), 32'd5);
    repeat (6) @(negedge Clk);
    chk("timing_done", 32'(n_done), 32'd1);
    chk("timing_words", 32'(words.size()), 32'd3);

    // Abort while in RUN.
    mdl_en = 1'b1; n_done = 0;
    cpt_pulse = 16'd1000; cpt_trigger = 16'd600;
    start_scan(10'd10, 10'd14, 10'd2);
    n = 0;
    while (!test_start && n < 50) begin @(negedge Clk); n++; end
    repeat (3) @(negedge Clk);
    scan_abort = 1'b1;
    @(negedge Clk);
    scan_abort = 1'b0;
    chk("abrun_test_start", 32'(test_start), 32'd0);
    chk("abrun_valid", 32'(bus.out_valid), 32'd0);
    chk("abrun_count_rst_n", 32'(count_rst_n), 32'd1);
    chk("abrun_busy", 32'(scan_busy), 32'd0);
    repeat (300) @(negedge Clk);
    chk("abrun_no_done", 32'(n_done), 32'd0);

    // Abort while in WR1.
    start_scan(10'd10, 10'd14, 10'd2);
    n = 0;
    while (!bus.out_valid && n < 400) begin @(negedge Clk); n++; end
    @(negedge Clk);
    chk("abwr1_data", 32'(bus.out_data), 32'd1000);
    scan_abort = 1'b1;
    @(negedge Clk);
    scan_abort = 1'b0;
    chk("abwr1_valid", 32'(bus.out_valid), 32'd0);
    chk("abwr1_busy", 32'(scan_busy), 32'd0);
    chk("abwr1_test_start", 32'(test_start), 32'd0);
    repeat (300) @(negedge Clk);
    chk("abwr1_no_done", 32'(n_done), 32'd0);

    // Abort and scan_start in the same IDLE cycle: start is ignored.
    @(negedge Clk);
    dac_start = 10'd10; dac_end = 10'd14; dac_step = 10'd2;
    scan_start = 1'b1; scan_abort = 1'b1;
    @(negedge Clk);
    scan_start = 1'b0; scan_abort = 1'b0;
    chk("abstart_busy", 32'(scan_busy), 32'd0);
    repeat (4) @(negedge Clk);
    chk("abstart_count_rst_n", 32'(count_rst_n), 32'd1);

    run_scan(vecs[0], 7);

    // Async reset in the middle of SETTLE.
    mdl_en = 1'b1; rdy_mode = 0; n_done = 0;
    start_scan(10'd10, 10'd14, 10'd2);
    n = 0;
    while (!dac_load && n < 30) begin @(negedge Clk); n++; end
    repeat (3) @(negedge Clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_count_rst_n", 32'(count_rst_n), 32'd1);
    chk("mrst_test_start", 32'(test_start), 32'd0);
    chk("mrst_dac_code", 32'(dac_code), 32'd0);
    chk("mrst_busy", 32'(scan_busy), 32'd0);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    n_load = 0;
    repeat (100) @(negedge Clk);
    chk("mrst_no_load", 32'(n_load), 32'd0);
    chk("mrst_no_done", 32'(n_done), 32'd0);
    chk("mrst_idle_test_start", 32'(test_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
